bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder_if.sv | 24 ++
 rtl/bus_mem_responder.sv | 118 +++++++++++
 tb/tb_bus_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_if.sv
// Request/handshake signals between an initiator and bus_mem_responder.
// The shared tri-state data bus is kept as a separate module port.
interface bus_mem_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              read_q;
  logic              write_q;
  logic              rw_halt;
  logic              read_dn;
  logic              write_dn;
  logic              busy;
  logic              proto_err;

  modport master (
    output addr, read_q, write_q, rw_halt,
    input  read_dn, write_dn, busy, proto_err
  );

  modport slave (
    input  addr, read_q, write_q, rw_halt,
    output read_dn, write_dn, busy, proto_err
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Word-addressed memory target with programmable wait states and a
// four-phase read/write handshake on a shared tri-state data bus.
module bus_mem_responder #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       MEM_AW      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  bus_mem_responder_if.slave  bus,
  inout  wire  [DATA_W-1:0]   data
);

  localparam logic [ADDR_W:0] WIN_SIZE = (ADDR_W+1)'(1) << MEM_AW;

  typedef enum logic [2:0] {IDLE, RWAIT, RRESP, WWAIT, WRESP} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [MEM_AW-1:0]   r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_drive;
  logic                r_read_dn;
  logic                r_write_dn;
  logic                r_busy;
  logic                r_proto_err;
  logic [DATA_W-1:0]   r_mem [2**MEM_AW];

  logic [ADDR_W-1:0]   w_off;
  logic                w_hit;

  assign w_off = bus.addr - BASE_ADDR;
  assign w_hit = (bus.addr >= BASE_ADDR) && ({1'b0, w_off} < WIN_SIZE);

  assign data          = r_drive ? r_rdata : 'z;
  assign bus.read_dn   = r_read_dn;
  assign bus.write_dn  = r_write_dn;
  assign bus.busy      = r_busy;
  assign bus.proto_err = r_proto_err;

  // Memory lives in the same block so the commit is gated by rst/rw_halt priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_drive     <= 1'b0;
      r_read_dn   <= 1'b0;
      r_write_dn  <= 1'b0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (bus.rw_halt && r_state != IDLE) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_drive    <= 1'b0;
      r_read_dn  <= 1'b0;
      r_write_dn <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.read_q && bus.write_q) begin
            r_proto_err <= 1'b1;
          end else if (w_hit && !bus.rw_halt && bus.read_q) begin
            r_idx   <= w_off[MEM_AW-1:0];
            r_cnt   <= 4'(WAIT_CYCLES);
            r_busy  <= 1'b1;
            r_state <= RWAIT;
          end else if (w_hit && !bus.rw_halt && bus.write_q) begin
            r_idx   <= w_off[MEM_AW-1:0];
            r_wdata <= data;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_busy  <= 1'b1;
            r_state <= WWAIT;
          end
        end
        RWAIT: begin
          if (r_cnt == '0) begin
            r_rdata   <= r_mem[r_idx];
            r_drive   <= 1'b1;
            r_read_dn <= 1'b1;
            r_state   <= RRESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RRESP: begin
          if (!bus.read_q) begin
            r_drive   <= 1'b0;
            r_read_dn <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        WWAIT: begin
          if (r_cnt == '0) begin
            r_mem[r_idx] <= r_wdata;
            r_write_dn   <= 1'b1;
            r_state      <= WRESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRESP: begin
          if (!bus.write_q) begin
            r_write_dn <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: main instance (BASE 0x100, 2 waits)
// and a zero-wait instance at BASE 0.
module tb_bus_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] PRB  = 32'h5A5A_C3C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bus_mem_responder_if #(.ADDR_W(32)) bif ();
  bus_mem_responder_if #(.ADDR_W(32)) bif0 ();

  wire  [31:0] data;
  wire  [31:0] data0;
  logic        tb_en  = 1'b0;
  logic [31:0] tb_val = '0;
  logic        tb_en0  = 1'b0;
  logic [31:0] tb_val0 = '0;

  assign data  = tb_en  ? tb_val  : 'z;
  assign data0 = tb_en0 ? tb_val0 : 'z;

  bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_AW(8), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bif.slave), .data(data)
  );

  bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_AW(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bif0.slave), .data(data0)
  );

  // Bus floats iff two complementary probe patterns read back unaltered.
  task automatic sense_float(output logic fl);
    logic [31:0] s1, s2;
    tb_en = 1'b1; tb_val = PRB;  #1; s1 = data;
    tb_val = ~PRB;               #1; s2 = data;
    tb_en = 1'b0;
    fl = (s1 === PRB) && (s2 === ~PRB);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat);
    bif.addr = a; tb_val = d; tb_en = 1'b1; bif.write_q = 1'b1;
    @(posedge clk); #1;
    bif.addr = a ^ 32'h3; tb_val = ~d;
    lat = 0;
    while (bif.write_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    tb_en = 1'b0; bif.write_q = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] rd);
    bif.addr = a; bif.read_q = 1'b1;
    @(posedge clk); #1;
    bif.addr = a ^ 32'h3;
    lat = 0;
    while (bif.read_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = data;
    bif.read_q = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic fl;
    bif.addr = '0; bif.read_q = 0; bif.write_q = 0; bif.rw_halt = 0;
    bif0.addr = '0; bif0.read_q = 0; bif0.write_q = 0; bif0.rw_halt = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bif.read_dn, bif.write_dn, bif.busy, bif.proto_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b want 0000", {bif.read_dn, bif.write_dn, bif.busy, bif.proto_err});
    end
    checks++;
    if ({bif0.read_dn, bif0.write_dn, bif0.busy, bif0.proto_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs0: got %b want 0000", {bif0.read_dn, bif0.write_dn, bif0.busy, bif0.proto_err});
    end
    sense_float(fl);
    checks++;
    if (fl !== 1'b1) begin errors++; $display("FAIL reset_float: got %b want 1", fl); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd;
    do_write(BASE + 32'd5, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d want 3", lat); end
    do_read(BASE + 32'd5, lat, rd);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_boundary();
    int lat; logic [31:0] rd;
    do_write(BASE + 32'd255, 32'hCAFEF00D, lat);
    do_read(BASE + 32'd255, lat, rd);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL last_index: got %h want cafef00d", rd); end
    do_write(BASE, 32'h0000_0001, lat);
    do_read(BASE, lat, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL first_index: got %h want 00000001", rd); end
  endtask

  task automatic test_out_of_window();
    logic ok, fl; int lat; logic [31:0] rd;
    ok = 1'b1;
    bif.addr = BASE + 32'd256; bif.read_q = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bif.read_dn !== 1'b0 || bif.busy !== 1'b0) ok = 1'b0;
      sense_float(fl);
      if (fl !== 1'b1) ok = 1'b0;
    end
    bif.read_q = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL above_window: got %b want 1", ok); end
    ok = 1'b1;
    bif.addr = BASE - 32'd1; tb_val = 32'h1111_1111; tb_en = 1'b1; bif.write_q = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bif.write_dn !== 1'b0 || bif.busy !== 1'b0) ok = 1'b0;
    end
    bif.write_q = 1'b0; tb_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL below_window: got %b want 1", ok); end
    do_read(BASE + 32'd255, lat, rd);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL below_window_mem: got %h want cafef00d", rd); end
  endtask

  task automatic test_abort_wwait();
    int lat; logic ok; logic [31:0] rd;
    do_write(BASE + 32'd7, 32'hA0A0A0A0, lat);
    bif.addr = BASE + 32'd7; tb_val = 32'h12345678; tb_en = 1'b1; bif.write_q = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bif.rw_halt = 1'b1; bif.write_q = 1'b0; tb_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bif.busy, bif.write_dn} !== 2'b00) begin
      errors++; $display("FAIL abort_wwait_idle: got %b want 00", {bif.busy, bif.write_dn});
    end
    bif.rw_halt = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bif.write_dn !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL abort_wwait_no_dn: got %b want 1", ok); end
    do_read(BASE + 32'd7, lat, rd);
    checks++;
    if (rd !== 32'hA0A0A0A0) begin errors++; $display("FAIL abort_wwait_mem: got %h want a0a0a0a0", rd); end
  endtask

  task automatic test_abort_wresp();
    int lat; logic [31:0] rd;
    bif.addr = BASE + 32'd8; tb_val = 32'h55AA55AA; tb_en = 1'b1; bif.write_q = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bif.write_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    bif.rw_halt = 1'b1; bif.write_q = 1'b0; tb_en = 1'b0;
    @(posedge clk); #1;
    bif.rw_halt = 1'b0;
    checks++;
    if ({bif.busy, bif.write_dn} !== 2'b00) begin
      errors++; $display("FAIL abort_wresp_idle: got %b want 00", {bif.busy, bif.write_dn});
    end
    do_read(BASE + 32'd8, lat, rd);
    checks++;
    if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL abort_wresp_mem: got %h want 55aa55aa", rd); end
  endtask

  task automatic test_abort_read_persist();
    logic fl; int lat;
    bif.addr = BASE + 32'd5; bif.read_q = 1'b1;
    @(posedge clk); #1;
    bif.rw_halt = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bif.busy, bif.read_dn} !== 2'b00) begin
      errors++; $display("FAIL abort_read_idle: got %b want 00", {bif.busy, bif.read_dn});
    end
    sense_float(fl);
    checks++;
    if (fl !== 1'b1) begin errors++; $display("FAIL abort_read_float: got %b want 1", fl); end
    bif.rw_halt = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bif.busy !== 1'b1) begin errors++; $display("FAIL persist_reaccept: got %b want 1", bif.busy); end
    lat = 0;
    while (bif.read_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL persist_data: got %h want deadbeef", data); end
    bif.read_q = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_handshake_hold();
    int lat; logic ok, fl;
    bif.addr = BASE + 32'd5; bif.read_q = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bif.read_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bif.read_dn !== 1'b1 || data !== 32'hDEADBEEF) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b want 1", ok); end
    bif.read_q = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bif.read_dn, bif.busy} !== 2'b00) begin
      errors++; $display("FAIL hold_release: got %b want 00", {bif.read_dn, bif.busy});
    end
    sense_float(fl);
    checks++;
    if (fl !== 1'b1) begin errors++; $display("FAIL hold_release_float: got %b want 1", fl); end
  endtask

  task automatic test_dual_request();
    logic fl; int lat; logic [31:0] rd;
    bif.addr = BASE + 32'd5; bif.read_q = 1'b1; bif.write_q = 1'b1;
    @(posedge clk); #1;
    bif.read_q = 1'b0; bif.write_q = 1'b0;
    checks++;
    if ({bif.proto_err, bif.busy} !== 2'b10) begin
      errors++; $display("FAIL dual_flag: got %b want 10", {bif.proto_err, bif.busy});
    end
    sense_float(fl);
    checks++;
    if (fl !== 1'b1) begin errors++; $display("FAIL dual_float: got %b want 1", fl); end
    do_write(BASE + 32'd9, 32'h0F0F_1234, lat);
    do_read(BASE + 32'd9, lat, rd);
    checks++;
    if (rd !== 32'h0F0F_1234) begin errors++; $display("FAIL dual_after_read: got %h want 0f0f1234", rd); end
    checks++;
    if (bif.proto_err !== 1'b1) begin errors++; $display("FAIL dual_sticky: got %b want 1", bif.proto_err); end
  endtask

  task automatic test_reset_mid();
    int lat; logic fl; logic [31:0] rd;
    bif.addr = BASE + 32'd5; bif.read_q = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bif.read_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bif.read_dn, bif.busy, bif.proto_err} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_read: got %b want 000", {bif.read_dn, bif.busy, bif.proto_err});
    end
    sense_float(fl);
    checks++;
    if (fl !== 1'b1) begin errors++; $display("FAIL rst_mid_float: got %b want 1", fl); end
    rst = 1'b0; bif.read_q = 1'b0;
    @(posedge clk); #1;
    bif.addr = BASE + 32'd5; tb_val = 32'h9999_9999; tb_en = 1'b1; bif.write_q = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; bif.write_q = 1'b0; tb_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(BASE + 32'd5, lat, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mem_kept: got %h want deadbeef", rd); end
  endtask

  task automatic test_zero_wait();
    int lat;
    bif0.addr = 32'd3; tb_val0 = 32'h0BADF00D; tb_en0 = 1'b1; bif0.write_q = 1'b1;
    @(posedge clk); #1;
    tb_val0 = 32'hFFFF0000;
    lat = 0;
    while (bif0.write_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zw_write_latency: got %0d want 1", lat); end
    tb_en0 = 1'b0; bif0.write_q = 1'b0;
    @(posedge clk); #1;
    bif0.read_q = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bif0.read_dn !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zw_read_latency: got %0d want 1", lat); end
    checks++;
    if (data0 !== 32'h0BADF00D) begin errors++; $display("FAIL zw_read_data: got %h want 0badf00d", data0); end
    bif0.read_q = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_boundary();
    test_out_of_window();
    test_abort_wwait();
    test_abort_wresp();
    test_abort_read_persist();
    test_handshake_hold();
    test_dual_request();
    test_reset_mid();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
